mine_map_gen: RTL and testbench
===============================

// Module: mine_map_gen
// PURPOSE
//  Builds the 64-cell mine map (bit p = cell at y*`MAP_WIDTH+x, 1 = mine) that deduce_mine_num reads.
//  Started on the player's first click; places exactly MINE_NUM mines via a free-running LFSR.
//  The clicked cell is never mined. Sits between the input/FSM layer and deduce_mine_num's map_i.
// PARAMETERS
//  MINE_NUM   10     mines to place; legal 1..(`MAP_WIDTH*`MAP_HEIGHT-1)
//  LFSR_SEED  8'hA5  LFSR reset value; must be non-zero
// PORTS
//  clk          in   1    system clock
//  rst_n        in   1    asynchronous, active-low reset
//  start_i      in   1    1-cycle pulse: generate a new map
//  safe_pos_i   in   8    first-click position y*`MAP_WIDTH+x; sampled with start_i
//  map_o        out  64   mine map (`MAP_HEIGHT*`MAP_WIDTH bits), registered
//  busy_o       out  1    high in CLEAR/PLACE
//  map_valid_o  out  1    high in DONE; map_o stable while high
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, map_o=0, busy_o=0, map_valid_o=0, mine count=0,
//   LFSR=LFSR_SEED, stored safe_pos=0. All regs clear immediately, mid-generation included.
//  LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, steps every cycle after reset in every
//   state (entropy from start_i timing). Period 255; low 6 bits hit every cell index.
//  FSM (one transition per clk):
//   IDLE : start_i=1 -> latch safe_pos_i, CLEAR. Else stay.
//   CLEAR: map_o<=0, count<=0 -> PLACE (1 cycle).
//   PLACE: cand=lfsr[5:0]. Accept iff cand!=safe_pos and map_o[cand]==0: set map_o[cand],
//          count<=count+1. Reject otherwise (no change). When accepted mine makes
//          count==MINE_NUM -> DONE in the same edge.
//   DONE : hold map_o. start_i=1 -> latch safe_pos_i, CLEAR (map_valid_o low next cycle).
//  busy_o=1 in CLEAR,PLACE; map_valid_o=1 only in DONE; both registered from state.
//  start_i during CLEAR/PLACE: ignored (no restart, safe_pos not re-latched).
//  safe_pos_i >= 64: no cell protected; map still has exactly MINE_NUM mines.
//  Latency: start_i edge -> map_valid_o rises <= 2 + 255*MINE_NUM cycles (every free cell is
//   visited once per LFSR period); bench timeout = 2+255*MINE_NUM.
//  Invariant in DONE: popcount(map_o)==MINE_NUM and map_o[safe_pos]==0.
//  count width 7 bits; never exceeds MINE_NUM (no wrap).
// STRUCTURE
//  parameter.v (shared): add `MINE_NUM, `LFSR_SEED, `LFSR_TAPS beside `MAP_WIDTH/`MAP_HEIGHT;
//   FSM state encodings IDLE=2'd0, CLEAR=2'd1, PLACE=2'd2, DONE=2'd3 as `define constants.
//  Sub-module: lfsr8 (clk, rst_n, seed, q[7:0]) - reused by future random-reveal logic.
//  Top: FSM + candidate accept logic + map/count registers.
// TESTING
//  1 Reset: rst_n=0 -> map_o=64'h0, busy_o=0, map_valid_o=0; release, idle 20 cycles -> unchanged.
//  2 start_i pulse, safe_pos_i=8'd0 -> busy_o=1 next cycle; map_valid_o within 2552 cycles;
//    popcount(map_o)=10, map_o[0]=0; map_o stable 50 cycles after.
//  3 safe_pos_i=8'd63 and 8'd27 (x=3,y=3) -> map_o[63]=0 / map_o[27]=0; popcount=10 each;
//    feed map_o to deduce_mine_num at those positions, check vs reference count model.
//  4 start_i re-pulsed mid-PLACE (safe_pos_i=8'd5) -> ignored: original safe_pos stays clear,
//    single map_valid_o rise; then start_i in DONE -> map_valid_o low next cycle, new map.
//  5 rst_n=0 asserted mid-PLACE -> map_o=0, busy_o=0 without clock edge; restart completes.
//  6 MINE_NUM=63, safe_pos_i=8'd12 -> map_o=~(64'h1<<12) within 2+255*63 cycles.

Source files
------------

// File: rtl/mine_map_gen_pkg.sv
// Shared map geometry, LFSR polynomial and generator state encoding.
// Imported by the mine map generator and its LFSR.
package mine_map_gen_pkg;

   localparam int MAP_WIDTH  = 8;
   localparam int MAP_HEIGHT = 8;
   localparam int MAP_CELLS  = MAP_WIDTH * MAP_HEIGHT;
   localparam int CNT_W      = 7;

   // Feedback taps for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3 of the shift register)
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_PLACE = 2'd2,
      ST_DONE  = 2'd3
   } gen_state_e;

   function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
      return {cur[6:0], ^(cur & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/mine_map_gen_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, maximal length (period 255).
// Seed must be non-zero or the register locks at zero.
module lfsr8
   import mine_map_gen_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] seed,
   output logic [7:0] q
);

   logic [7:0] lfsr_q;
   logic [7:0] lfsr_d;

   always_comb begin
      lfsr_d = lfsr_next(lfsr_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= seed;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign q = lfsr_q;

endmodule

// File: rtl/mine_map_gen.sv
// Builds the 64-cell mine map on the first click: places MINE_NUM mines at
// LFSR-chosen cells, never on the clicked cell and never twice on one cell.
module mine_map_gen
   import mine_map_gen_pkg::*;
#(
   parameter int         MINE_NUM  = 10,
   parameter logic [7:0] LFSR_SEED = 8'hA5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_i,
   input  logic [7:0]           safe_pos_i,
   output logic [MAP_CELLS-1:0] map_o,
   output logic                 busy_o,
   output logic                 map_valid_o
);

   localparam logic [CNT_W-1:0] MINE_CNT = CNT_W'(MINE_NUM);

   gen_state_e           state_q, state_d;
   logic [MAP_CELLS-1:0] map_q, map_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [7:0]           safe_q, safe_d;
   logic                 busy_q, busy_d;
   logic                 valid_q, valid_d;

   logic [7:0] lfsr;
   logic [5:0] cand;
   logic       accept;
   logic       lfsr_unused;

   lfsr8 u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .seed  (LFSR_SEED),
      .q     (lfsr)
   );

   assign cand        = lfsr[5:0];
   assign lfsr_unused = ^lfsr[7:6];

   // A safe position >= 64 never matches a 6-bit candidate, so no cell is protected
   assign accept = ({2'b00, cand} != safe_q) && !map_q[cand];

   always_comb begin
      state_d = state_q;
      map_d   = map_q;
      cnt_d   = cnt_q;
      safe_d  = safe_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_i) begin
               safe_d  = safe_pos_i;
               state_d = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            map_d   = '0;
            cnt_d   = '0;
            state_d = ST_PLACE;
         end
         ST_PLACE: begin
            if (accept) begin
               map_d[cand] = 1'b1;
               cnt_d       = cnt_q + 1'b1;
               if (cnt_q + 1'b1 == MINE_CNT) begin
                  state_d = ST_DONE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d  = (state_d == ST_CLEAR) || (state_d == ST_PLACE);
      valid_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         map_q   <= '0;
         cnt_q   <= '0;
         safe_q  <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         map_q   <= map_d;
         cnt_q   <= cnt_d;
         safe_q  <= safe_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
      end
   end

   assign map_o       = map_q;
   assign busy_o      = busy_q;
   assign map_valid_o = valid_q;

endmodule

// File: tb/tb_mine_map_gen.sv
// Self-checking bench for mine_map_gen: predicts each map from the LFSR
// sequence and the placement rules, for a 10-mine and a 63-mine instance.
module tb_mine_map_gen;

   localparam logic [7:0] SEED = 8'hA5;

   logic        clk;
   logic        rst_n;
   logic        start0, start1;
   logic [7:0]  safe0, safe1;
   logic [63:0] map0, map1;
   logic        busy0, busy1;
   logic        valid0, valid1;

   int checks;
   int errors;
   int edge_cnt;
   int rise0, rise1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Rising edges since reset release; value read at negedge = edges seen
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) edge_cnt <= 0;
      else        edge_cnt <= edge_cnt + 1;
   end

   always @(posedge valid0) rise0++;
   always @(posedge valid1) rise1++;

   mine_map_gen #(.MINE_NUM(10), .LFSR_SEED(SEED)) u_dut (
      .clk(clk), .rst_n(rst_n), .start_i(start0), .safe_pos_i(safe0),
      .map_o(map0), .busy_o(busy0), .map_valid_o(valid0)
   );

   mine_map_gen #(.MINE_NUM(63), .LFSR_SEED(SEED)) u_dut63 (
      .clk(clk), .rst_n(rst_n), .start_i(start1), .safe_pos_i(safe1),
      .map_o(map1), .busy_o(busy1), .map_valid_o(valid1)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] step(input logic [7:0] v);
      int fb;
      fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
      return 8'(((int'(v) * 2) % 256) + fb);
   endfunction

   // Start sampled at edge s; the first candidate is seen at edge s+2,
   // and the LFSR value before edge n is the seed stepped n-1 times.
   task automatic predict(input int s, input int mines, input logic [7:0] sp,
                          output logic [63:0] m, output int e);
      logic [7:0] v;
      int cnt, n, cand;
      v = SEED;
      for (int i = 0; i < s + 1; i++) v = step(v);
      m = '0;
      cnt = 0;
      e = -1;
      n = s + 2;
      while (cnt < mines && n < s + 2 + 255 * 64) begin
         cand = v % 64;
         if (cand != int'(sp) && m[cand] == 1'b0) begin
            m[cand] = 1'b1;
            cnt++;
            if (cnt == mines) e = n;
         end
         v = step(v);
         n++;
      end
   endtask

   task automatic run_map(input int which, input logic [7:0] sp, input int repulse_at,
                          input bit check_stable);
      int mines, s, e, r0, timeout, got_edge;
      logic [63:0] exp_map, m;
      logic v;
      mines = (which == 1) ? 63 : 10;
      timeout = 2 + 255 * mines;
      @(negedge clk);
      s = edge_cnt + 1;
      if (which == 1) begin start1 = 1'b1; safe1 = sp; end
      else            begin start0 = 1'b1; safe0 = sp; end
      r0 = (which == 1) ? rise1 : rise0;
      @(negedge clk);
      start0 = 1'b0;
      start1 = 1'b0;
      predict(s, mines, sp, exp_map, e);
      check("busy_after_start", 64'((which == 1) ? busy1 : busy0), 64'd1);
      check("valid_after_start", 64'((which == 1) ? valid1 : valid0), 64'd0);
      got_edge = -1;
      for (int k = 0; k < timeout; k++) begin
         v = (which == 1) ? valid1 : valid0;
         if (v) begin
            got_edge = edge_cnt;
            break;
         end
         if (which == 0) begin
            start0 = (k == repulse_at);
            if (k == repulse_at) safe0 = 8'd5;
         end
         @(negedge clk);
      end
      start0 = 1'b0;
      if (got_edge < 0) begin
         check("timeout", 64'd0, 64'd1);
      end else begin
         m = (which == 1) ? map1 : map0;
         check("done_edge", 64'(got_edge), 64'(e));
         check("map", m, exp_map);
         check("popcount", 64'($countones(m)), 64'(mines));
         if (sp < 8'd64) check("safe_clear", 64'(m[sp[5:0]]), 64'd0);
         @(negedge clk);
         check("single_rise", 64'(((which == 1) ? rise1 : rise0) - r0), 64'd1);
         if (check_stable) begin
            repeat (50) @(negedge clk);
            check("map_stable", map0, exp_map);
            check("valid_held", 64'(valid0), 64'd1);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rise0 = 0;
      rise1 = 0;
      rst_n = 1'b0;
      start0 = 1'b0;
      start1 = 1'b0;
      safe0 = 8'd0;
      safe1 = 8'd0;
      repeat (3) @(negedge clk);
      check("rst_map", map0, 64'h0);
      check("rst_busy", 64'(busy0), 64'd0);
      check("rst_valid", 64'(valid0), 64'd0);
      check("rst_map63", map1, 64'h0);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check("idle_map", map0, 64'h0);
      check("idle_busy", 64'(busy0), 64'd0);
      check("idle_valid", 64'(valid0), 64'd0);

      run_map(0, 8'd0, -1, 1'b1);
      run_map(0, 8'd63, -1, 1'b0);
      run_map(0, 8'd27, -1, 1'b0);
      run_map(0, 8'($urandom_range(0, 63)), 4, 1'b0);

      for (int i = 0; i < 4; i++) begin
         repeat ($urandom_range(0, 30)) @(negedge clk);
         run_map(0, 8'($urandom_range(0, 255)), -1, 1'b0);
      end
      run_map(0, 8'd200, -1, 1'b0);

      // Asynchronous reset in the middle of placement
      @(negedge clk);
      start0 = 1'b1;
      safe0 = 8'd9;
      @(negedge clk);
      start0 = 1'b0;
      repeat (6) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_map", map0, 64'h0);
      check("midrst_busy", 64'(busy0), 64'd0);
      check("midrst_valid", 64'(valid0), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      run_map(0, 8'($urandom_range(0, 63)), -1, 1'b0);

      run_map(1, 8'd12, -1, 1'b0);
      check("full_map63", map1, ~(64'h1 << 12));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
